// File: rtl/loopback_test_sequencer.sv
// Pin-integrity bring-up sequencer: walks a fixed pattern set through an inverting
// loopback path, checks each returned word and the tie-high pins, and reports a summary.
module loopback_test_sequencer #(
    parameter int NUM_PINS      = 4,
    parameter int NUM_TIES      = 2,
    parameter int SETTLE_CYCLES = 2,
    localparam int NUM_PATS     = NUM_PINS + 2,
    localparam int IDX_W        = $clog2(NUM_PINS + 2),
    localparam int CNT_W        = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    output logic [NUM_PINS-1:0] dut_in,
    input  logic [NUM_PINS-1:0] dut_out,
    input  logic [NUM_TIES-1:0] tie_in,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [7:0]          err_count,
    output logic [IDX_W-1:0]    fail_index,
    output logic                fail_valid
);

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(NUM_PATS - 1);

    state_t             state;
    logic [CNT_W-1:0]   settle_cnt;
    logic [IDX_W-1:0]   pat_idx;
    logic               pattern_fail;
    logic [7:0]         err_next;

    // idx0 all-zeros, idx1 all-ones, then a walking one from bit 0 upward.
    function automatic logic [NUM_PINS-1:0] pattern_at(input logic [IDX_W-1:0] idx);
        logic [NUM_PINS-1:0] pat;
        pat = '0;
        if (idx == IDX_W'(0)) begin
            pat = '0;
        end else if (idx == IDX_W'(1)) begin
            pat = '1;
        end else begin
            pat = NUM_PINS'(1) << (idx - IDX_W'(2));
        end
        return pat;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] count);
        return (count == 8'hFF) ? count : count + 8'd1;
    endfunction

    always_comb begin
        pattern_fail = (dut_out != ~dut_in) || (tie_in != {NUM_TIES{1'b1}});
        err_next     = pattern_fail ? sat_inc(err_count) : err_count;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            settle_cnt <= '0;
            pat_idx    <= '0;
            dut_in     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            fail_index <= '0;
            fail_valid <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_idx    <= '0;
                        dut_in     <= pattern_at('0);
                        err_count  <= '0;
                        fail_valid <= 1'b0;
                        fail_index <= '0;
                        pass       <= 1'b0;
                        settle_cnt <= SETTLE_LOAD;
                        busy       <= 1'b1;
                        state      <= SETTLE;
                    end
                end

                SETTLE: begin
                    if (abort) begin
                        dut_in <= '0;
                        pass   <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else if (settle_cnt == '0) begin
                        state <= CHECK;
                    end else begin
                        settle_cnt <= settle_cnt - CNT_W'(1);
                    end
                end

                CHECK: begin
                    // Abort wins over the sample taken on this edge.
                    if (abort) begin
                        dut_in <= '0;
                        pass   <= 1'b0;
                        busy   <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        err_count <= err_next;
                        if (pattern_fail && !fail_valid) begin
                            fail_index <= pat_idx;
                            fail_valid <= 1'b1;
                        end
                        if (pat_idx == LAST_IDX) begin
                            pass  <= (err_next == 8'd0);
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= DONE;
                        end else begin
                            pat_idx    <= pat_idx + IDX_W'(1);
                            dut_in     <= pattern_at(pat_idx + IDX_W'(1));
                            settle_cnt <= SETTLE_LOAD;
                            state      <= SETTLE;
                        end
                    end
                end

                DONE: begin
                    dut_in <= '0;
                    state  <= IDLE;
                end

                default: begin
                    dut_in <= '0;
                    busy   <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule
